// File: rtl/pulse_width_checker.sv
// Multi-channel monitor: each channel's high runs must last between min and max samples.
// Violations pulse for one cycle, latch into a sticky bit, and the run length is captured.
module pulse_width_checker #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 4,
  parameter int DEF_MIN = 2,
  parameter int DEF_MAX = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH-1:0]       sig,
  input  logic                  cfg_we,
  input  logic [CNT_W-1:0]      cfg_min,
  input  logic [CNT_W-1:0]      cfg_max,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       ok_pulse,
  output logic [N_CH-1:0]       short_err,
  output logic [N_CH-1:0]       long_err,
  output logic [N_CH-1:0]       err_sticky,
  output logic [N_CH*CNT_W-1:0] last_len,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {IDLE, HIGH, OVER} state_t;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_RST = CNT_W'(DEF_MIN);
  localparam logic [CNT_W-1:0] MAX_RST = CNT_W'(DEF_MAX);

  logic [CNT_W-1:0]      min_q, max_q;
  state_t                state_q [N_CH];
  state_t                state_d [N_CH];
  logic [CNT_W-1:0]      cnt_q   [N_CH];
  logic [CNT_W-1:0]      cnt_d   [N_CH];
  logic [N_CH-1:0]       ok_d, short_d, long_d;
  logic [N_CH*CNT_W-1:0] len_d;
  logic                  bounds_bad;
  logic                  hold_idle;

  // max must stay below saturation so the OVER count (max+1) is representable
  assign bounds_bad = (min_q == '0) || (min_q > max_q) || (max_q == CNT_SAT);
  assign hold_idle  = cfg_we || !en || bounds_bad;

  always_comb begin
    ok_d    = '0;
    short_d = '0;
    long_d  = '0;
    len_d   = last_len;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (hold_idle) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (sig[i]) begin
              state_d[i] = HIGH;
              cnt_d[i]   = CNT_ONE;
            end
          end
          HIGH: begin
            if (sig[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
              if (cnt_q[i] == max_q) begin
                state_d[i] = OVER;
                long_d[i]  = 1'b1;
              end
            end else begin
              state_d[i]              = IDLE;
              cnt_d[i]                = '0;
              len_d[i*CNT_W +: CNT_W] = cnt_q[i];
              if (cnt_q[i] < min_q) short_d[i] = 1'b1;
              else                  ok_d[i]    = 1'b1;
            end
          end
          OVER: begin
            if (sig[i]) begin
              if (cnt_q[i] != CNT_SAT) cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
              state_d[i]              = IDLE;
              cnt_d[i]                = '0;
              len_d[i*CNT_W +: CNT_W] = cnt_q[i];
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Registered outputs: flags appear on the same edge that samples sig
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q      <= MIN_RST;
      max_q      <= MAX_RST;
      cfg_err    <= 1'b0;
      ok_pulse   <= '0;
      short_err  <= '0;
      long_err   <= '0;
      err_sticky <= '0;
      last_len   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (cfg_we) begin
        min_q <= cfg_min;
        max_q <= cfg_max;
      end
      cfg_err    <= bounds_bad;
      ok_pulse   <= ok_d;
      short_err  <= short_d;
      long_err   <= long_d;
      err_sticky <= (err_sticky & ~clr) | short_d | long_d;
      last_len   <= len_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_checker.sv
// Directed bench for pulse_width_checker: a per-cycle vector table plus
// hand-written sequences for configuration, sticky-clear priority and reset.
module tb_pulse_width_checker;

  logic        clk = 1'b0;
  logic        rst, en, cfg_we, cfg_err;
  logic [3:0]  sig, clr, cfg_min, cfg_max;
  logic [3:0]  ok_pulse, short_err, long_err, err_sticky;
  logic [15:0] last_len;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  acc;

  always #5 clk = ~clk;

  pulse_width_checker #(.N_CH(4), .CNT_W(4), .DEF_MIN(2), .DEF_MAX(6)) dut (
    .clk(clk), .rst(rst), .en(en), .sig(sig), .cfg_we(cfg_we),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .clr(clr),
    .ok_pulse(ok_pulse), .short_err(short_err), .long_err(long_err),
    .err_sticky(err_sticky), .last_len(last_len), .cfg_err(cfg_err)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [3:0]  sig, clr, ok, sh, lg, st;
    logic [15:0] len;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic e, input logic [3:0] s, c,
                              input logic [3:0] ok, sh, lg, st, input logic [15:0] len);
    vec_t v;
    v.name = name; v.en = e; v.sig = s; v.clr = c;
    v.ok = ok; v.sh = sh; v.lg = lg; v.st = st; v.len = len;
    vecs.push_back(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] ok, sh, lg, st,
                            input logic [15:0] len);
    check({name, ".ok"},     {28'd0, ok_pulse},   {28'd0, ok});
    check({name, ".short"},  {28'd0, short_err},  {28'd0, sh});
    check({name, ".long"},   {28'd0, long_err},   {28'd0, lg});
    check({name, ".sticky"}, {28'd0, err_sticky}, {28'd0, st});
    check({name, ".len"},    {16'd0, last_len},   {16'd0, len});
  endtask

  task automatic write_cfg(input logic [3:0] mn, input logic [3:0] mx);
    cfg_min = mn; cfg_max = mx; cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; sig = '0; clr = '0; cfg_we = 1'b0; cfg_min = '0; cfg_max = '0;

    // Per-cycle table, bounds at defaults 2..6
    add("idle",     1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    add("p2_h1",    1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    add("p2_h2",    1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    add("p2_end",   1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0002);
    for (int i = 0; i < 6; i++)
      add("p6_high", 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0002);
    add("p6_end",   1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0006);
    for (int i = 0; i < 6; i++)
      add("p7_high", 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0006);
    add("p7_long",  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 16'h0006);
    add("p7_over",  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'h0006);
    add("p7_end",   1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'h0008);
    add("c12_h1",   1, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 16'h0008);
    add("c1_short", 1, 4'h4, 4'h0, 4'h0, 4'h2, 4'h0, 4'h3, 16'h0018);
    add("c2_h3",    1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 16'h0018);
    add("c2_ok",    1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h3, 16'h0318);
    add("clr01",    1, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0318);
    add("all_h1",   1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0318);
    add("all_h2",   1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0318);
    add("all_ok",   1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_a1",   1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_a2",   1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_aok",  1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_b1",   1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_b2",   1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_b3",   1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2222);
    add("b2b_bok",  1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 16'h2223);
    add("en_h1",    1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2223);
    add("en_off",   0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2223);
    add("en_rest",  1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h2223);
    add("en_short", 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 16'h2221);

    tick; tick;
    check_outs("reset", 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    check("reset.cfg_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      en = vecs[k].en; sig = vecs[k].sig; clr = vecs[k].clr;
      tick;
      check_outs(vecs[k].name, vecs[k].ok, vecs[k].sh, vecs[k].lg, vecs[k].st, vecs[k].len);
    end
    en = 1'b1; clr = '0; sig = '0;

    // Invalid bounds suppress all checking
    write_cfg(4'd3, 4'd2);
    check("badcfg.cfg_err", {31'd0, cfg_err}, 32'd1);
    acc = '0;
    sig = 4'h3; tick; acc |= ok_pulse | short_err | long_err;
    sig = 4'h1;
    for (int i = 0; i < 8; i++) begin tick; acc |= ok_pulse | short_err | long_err; end
    sig = 4'h0; tick; acc |= ok_pulse | short_err | long_err;
    check("badcfg.no_flags", {28'd0, acc}, 32'd0);
    check("badcfg.len_hold", {16'd0, last_len}, 32'h2221);

    write_cfg(4'd3, 4'd4);
    check("cfg34.cfg_err", {31'd0, cfg_err}, 32'd0);
    sig = 4'h1;
    for (int i = 0; i < 4; i++) tick;
    sig = 4'h0; tick;
    check_outs("cfg34_p4", 4'h1, 4'h0, 4'h0, 4'h1, 16'h2224);

    // cfg_we mid-pulse discards the run; counting restarts afterwards
    acc = '0;
    sig = 4'h1; tick; tick;
    cfg_min = 4'd3; cfg_max = 4'd4; cfg_we = 1'b1;
    tick; acc |= ok_pulse | short_err | long_err;
    cfg_we = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; acc |= ok_pulse | short_err | long_err; end
    check("discard.no_flags", {28'd0, acc}, 32'd0);
    sig = 4'h0; tick;
    check_outs("discard_end", 4'h1, 4'h0, 4'h0, 4'h1, 16'h2223);

    // Same-cycle set beats clear
    write_cfg(4'd2, 4'd6);
    clr = 4'h1; tick; clr = 4'h0;
    check("clr_alone0", {28'd0, err_sticky}, 32'd0);
    sig = 4'h1;
    for (int i = 0; i < 6; i++) tick;
    clr = 4'h1; tick;
    check("setwins.long", {28'd0, long_err}, 32'h1);
    check("setwins.sticky", {28'd0, err_sticky}, 32'h1);
    clr = 4'h0; sig = 4'h0; tick;
    check_outs("over_end", 4'h0, 4'h0, 4'h0, 4'h1, 16'h2227);
    clr = 4'h1; tick; clr = 4'h0;
    check("clr_alone1", {28'd0, err_sticky}, 32'd0);

    // Reset mid-pulse restores 2..6 and restarts the count
    write_cfg(4'd3, 4'd4);
    sig = 4'h8; tick; sig = 4'h0; tick;
    check("pre_rst.sticky", {28'd0, err_sticky}, 32'h8);
    sig = 4'h1; tick; tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    check_outs("midrst", 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
    check("midrst.cfg_err", {31'd0, cfg_err}, 32'd0);
    acc = '0;
    for (int i = 0; i < 6; i++) begin tick; acc |= ok_pulse | short_err | long_err; end
    check("postrst.no_early", {28'd0, acc}, 32'd0);
    tick;
    check("postrst.long7", {28'd0, long_err}, 32'h1);
    sig = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_width_checker.md
Name: pulse_width_checker

Overview:
- Multi-channel synthesizable monitor checking that each input signal stays high for at least MIN and at most MAX consecutive clock samples.
- Generalises the single-signal high-for-2-to-6-cycles property check into RTL: N channels, runtime-programmable bounds, per-channel state machines, registered violation pulses, sticky status and measured pulse width.
- Sits beside DUT signals in testbenches and on-chip debug logic.

Parameters:
- N_CH, 4, number of independent monitored channels.
- CNT_W, 4, width of the per-channel run-length counter and of the length fields.
- DEF_MIN, 2, value loaded into the min bound register at reset.
- DEF_MAX, 6, value loaded into the max bound register at reset.

Ports:
- clk  input  1  clock; all sampling on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low forces all channels to IDLE, no flags.
- sig  input  N_CH  monitored signals, bit i = channel i.
- cfg_we  input  1  loads cfg_min/cfg_max into the bound registers.
- cfg_min  input  CNT_W  new minimum high length.
- cfg_max  input  CNT_W  new maximum high length.
- clr  input  N_CH  per-channel sticky-error clear.
- ok_pulse  output  N_CH  1-cycle: legal pulse completed.
- short_err  output  N_CH  1-cycle: pulse ended with length < min.
- long_err  output  N_CH  1-cycle: high run reached max+1.
- err_sticky  output  N_CH  latched OR of short_err|long_err.
- last_len  output  N_CH*CNT_W  length of last completed pulse, channel i at [i*CNT_W +: CNT_W].
- cfg_err  output  1  bound registers invalid; checking suppressed.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, bound registers = DEF_MIN/DEF_MAX, all channels IDLE, counters 0.
- Outputs are registers updated on the same posedge that samples sig; no further latency.
- cfg_err = !(1 <= min <= max < 2^CNT_W-1), registered from the bound registers; while 1, all channels held in IDLE, no ok/short/long pulses.
- cfg_we: bounds update at the posedge; all channels return to IDLE at that edge (any in-flight pulse is discarded, no flag raised).
- Per-channel FSM, states IDLE, HIGH, OVER:
  - IDLE, sig=1: go HIGH, cnt=1.
  - IDLE, sig=0: stay.
  - HIGH, sig=1, cnt < max: cnt+1.
  - HIGH, sig=1, cnt == max: go OVER, long_err=1 this edge (the (max+1)th high sample), err_sticky set.
  - HIGH, sig=0, cnt < min: short_err=1, last_len=cnt, go IDLE.
  - HIGH, sig=0, min <= cnt <= max: ok_pulse=1, last_len=cnt, go IDLE.
  - OVER, sig=1: stay, no further flags, cnt saturates at 2^CNT_W-1.
  - OVER, sig=0: last_len=saturated cnt, go IDLE, no ok/short flag.
- Back-to-back: a low sample between pulses is required; a single 0 sample ends one pulse, and the next 1 starts a new one from cnt=1.
- en=0: FSMs to IDLE, cnt=0, pulses 0; err_sticky and last_len hold.
- Sticky bits:
  - clr[i] clears err_sticky[i].
  - Same-cycle new error and clr[i]: set wins.
- Channels are fully independent; simultaneous events on several channels are each reported in the same cycle.
- Reset mid-pulse: pulse discarded; if sig is still high after release, counting restarts at cnt=1 on the first non-reset edge.

Test Plan:
- Defaults (2,6); ch0 high for 2 samples then low -> ok_pulse[0]=1 on the low-sample edge, last_len[0]=2, err_sticky=0.
- ch0 high 6 samples -> ok_pulse, last_len=6.
- ch0 high 7 samples -> long_err[0] on the 7th high edge, single pulse only; on the later low, no ok_pulse, err_sticky[0]=1.
- ch1 high 1 sample -> short_err[1]=1, last_len[1]=1. Simultaneously ch2 runs a 3-sample pulse -> ok_pulse[2] independent of ch1.
- cfg_we with min=3, max=2 -> cfg_err=1 and no flags for any pulse. Then cfg_we with min=3, max=4 and a 4-sample pulse -> ok_pulse.
- err_sticky[0]=1; clr[0] in the same cycle as a new long_err[0] -> sticky stays 1. clr[0] alone -> 0.
- rst asserted during a 5-sample pulse -> all outputs 0, bounds 2/6. sig held high 7 more samples -> long_err on the 7th post-reset edge.
